// File: rtl/gpio_reg_gen2_pkg.sv
// rtl/gpio_reg_gen2_pkg.sv - gpio_pkg: register map offsets and byte-enable helper
package gpio_pkg;

  localparam logic [3:0] GPIO_ADDR_DIR      = 4'd0;
  localparam logic [3:0] GPIO_ADDR_OTYPE    = 4'd1;
  localparam logic [3:0] GPIO_ADDR_IN       = 4'd2;
  localparam logic [3:0] GPIO_ADDR_OUT      = 4'd3;
  localparam logic [3:0] GPIO_ADDR_OUT_SET  = 4'd4;
  localparam logic [3:0] GPIO_ADDR_OUT_CLR  = 4'd5;
  localparam logic [3:0] GPIO_ADDR_OUT_TGL  = 4'd6;
  localparam logic [3:0] GPIO_ADDR_INT_STAT = 4'd7;
  localparam logic [3:0] GPIO_ADDR_INT_SET  = 4'd8;
  localparam logic [3:0] GPIO_ADDR_INT_MASK = 4'd9;
  localparam logic [3:0] GPIO_ADDR_POS_SEL  = 4'd10;
  localparam logic [3:0] GPIO_ADDR_NEG_SEL  = 4'd11;
  localparam logic [3:0] GPIO_ADDR_LVL_SEL  = 4'd12;
  localparam logic [3:0] GPIO_ADDR_DEB_CFG  = 4'd13;
  localparam int         GPIO_MAP_SIZE      = 16;

  function automatic logic [31:0] be2mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_reg_gen2_if.sv
// rtl/gpio_reg_gen2_if.sv - register bus between pinmux decoder (master) and GPIO block (slave)
interface gpio_reg_gen2_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
                  input  reg_rdata, reg_ack);
  modport slave  (input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
                  output reg_rdata, reg_ack);
endinterface

// File: rtl/gpio_reg_gen2_deb_cell.sv
// rtl/gpio_reg_gen2_deb_cell.sv - gpio_deb_cell: one-pin debouncer, filt follows sync_i after cfg_i+1 stable cycles
module gpio_deb_cell #(
  parameter int CNT_WD = 8
) (
  input  logic              mclk,
  input  logic              h_reset,
  input  logic              sync_i,
  input  logic [CNT_WD-1:0] cfg_i,
  output logic              filt_o
);

  logic              filt_q, filt_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;

  // Counter reloads whenever input agrees with filt, so a new cfg_i is picked up on restart.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync_i == filt_q) begin
      cnt_d = cfg_i;
    end else if (cnt_q == '0) begin
      filt_d = sync_i;
      cnt_d  = cfg_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/gpio_reg_gen2.sv
// rtl/gpio_reg_gen2.sv - GPIO register block: out/dir/open-drain, input sync+filter, edge/level interrupts
// Optional per-pin debounce selected by GPIO_DEBOUNCE_EN.
module gpio_reg_gen2
  import gpio_pkg::*;
#(
  parameter int GPIO_WD     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_WD  = 8
) (
  input  logic               mclk,
  input  logic               h_reset,
  gpio_reg_gen2_if.slave     bus,
  input  logic [GPIO_WD-1:0] gpio_in_data,
  output logic [GPIO_WD-1:0] gpio_out_data,
  output logic [GPIO_WD-1:0] gpio_out_en,
  output logic [GPIO_WD-1:0] gpio_int_stat,
  output logic               gpio_intr
);

  if (GPIO_WD < 1 || GPIO_WD > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
      DEB_CNT_WD < 1 || DEB_CNT_WD > 32) begin : g_bad_param
    $error("gpio_reg_gen2: parameter out of range");
  end

  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               access, wr_en;
  logic [31:0]        be_mask;
  logic [GPIO_WD-1:0] wmask, wbits, w1c, w1s, evt;
  logic [GPIO_WD-1:0] dir_q, dir_d, otype_q, otype_d, out_q, out_d, stat_q, stat_d;
  logic [GPIO_WD-1:0] mask_q, mask_d, pos_q, pos_d, neg_q, neg_d, lvl_q, lvl_d;
  logic [GPIO_WD-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WD-1:0] filt, filt_dly_q;
  logic [31:0]        deb_rd;

  // One commit per access: the ack cycle itself masks a still-asserted reg_cs.
  assign access  = bus.reg_cs & ~ack_q;
  assign wr_en   = access & bus.reg_wr;
  assign be_mask = be2mask(bus.reg_be);
  assign wmask   = be_mask[GPIO_WD-1:0];
  assign wbits   = bus.reg_wdata[GPIO_WD-1:0] & wmask;

`ifdef GPIO_DEBOUNCE_EN
  logic [DEB_CNT_WD-1:0] deb_cfg_q, deb_cfg_d;

  always_comb begin
    deb_cfg_d = deb_cfg_q;
    if (wr_en && bus.reg_addr == GPIO_ADDR_DEB_CFG)
      deb_cfg_d = (deb_cfg_q & ~be_mask[DEB_CNT_WD-1:0]) |
                  (bus.reg_wdata[DEB_CNT_WD-1:0] & be_mask[DEB_CNT_WD-1:0]);
  end

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) deb_cfg_q <= '0;
    else         deb_cfg_q <= deb_cfg_d;
  end

  for (genvar g = 0; g < GPIO_WD; g++) begin : g_deb
    gpio_deb_cell #(.CNT_WD(DEB_CNT_WD)) u_cell (
      .mclk    (mclk),
      .h_reset (h_reset),
      .sync_i  (sync_q[SYNC_STAGES-1][g]),
      .cfg_i   (deb_cfg_q),
      .filt_o  (filt[g])
    );
  end
  assign deb_rd = 32'(deb_cfg_q);
`else
  logic [GPIO_WD-1:0] filt_q;

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) filt_q <= '0;
    else         filt_q <= sync_q[SYNC_STAGES-1];
  end
  assign filt   = filt_q;
  assign deb_rd = '0;
`endif

  assign evt = (lvl_q & ((pos_q & filt) | (neg_q & ~filt))) |
               (~lvl_q & ((pos_q & filt & ~filt_dly_q) | (neg_q & ~filt & filt_dly_q)));

  always_comb begin
    dir_d   = dir_q;
    otype_d = otype_q;
    out_d   = out_q;
    mask_d  = mask_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    lvl_d   = lvl_q;
    w1c     = '0;
    w1s     = '0;
    if (wr_en) begin
      case (bus.reg_addr)
        GPIO_ADDR_DIR:      dir_d   = (dir_q & ~wmask) | wbits;
        GPIO_ADDR_OTYPE:    otype_d = (otype_q & ~wmask) | wbits;
        GPIO_ADDR_OUT:      out_d   = (out_q & ~wmask) | wbits;
        GPIO_ADDR_OUT_SET:  out_d   = out_q | wbits;
        GPIO_ADDR_OUT_CLR:  out_d   = out_q & ~wbits;
        GPIO_ADDR_OUT_TGL:  out_d   = out_q ^ wbits;
        GPIO_ADDR_INT_STAT: w1c     = wbits;
        GPIO_ADDR_INT_SET:  w1s     = wbits;
        GPIO_ADDR_INT_MASK: mask_d  = (mask_q & ~wmask) | wbits;
        GPIO_ADDR_POS_SEL:  pos_d   = (pos_q & ~wmask) | wbits;
        GPIO_ADDR_NEG_SEL:  neg_d   = (neg_q & ~wmask) | wbits;
        GPIO_ADDR_LVL_SEL:  lvl_d   = (lvl_q & ~wmask) | wbits;
        default: ;
      endcase
    end
    // Set (hardware or W1S) wins over a same-cycle clear.
    stat_d = (stat_q & ~w1c) | evt | w1s;
  end

  always_comb begin
    rdata_d = '0;
    case (bus.reg_addr)
      GPIO_ADDR_DIR:      rdata_d = 32'(dir_q);
      GPIO_ADDR_OTYPE:    rdata_d = 32'(otype_q);
      GPIO_ADDR_IN:       rdata_d = 32'(filt);
      GPIO_ADDR_OUT, GPIO_ADDR_OUT_SET,
      GPIO_ADDR_OUT_CLR, GPIO_ADDR_OUT_TGL:   rdata_d = 32'(out_q);
      GPIO_ADDR_INT_STAT, GPIO_ADDR_INT_SET:  rdata_d = 32'(stat_q);
      GPIO_ADDR_INT_MASK: rdata_d = 32'(mask_q);
      GPIO_ADDR_POS_SEL:  rdata_d = 32'(pos_q);
      GPIO_ADDR_NEG_SEL:  rdata_d = 32'(neg_q);
      GPIO_ADDR_LVL_SEL:  rdata_d = 32'(lvl_q);
      GPIO_ADDR_DEB_CFG:  rdata_d = deb_rd;
      default: ;
    endcase
  end

  always_ff @(posedge mclk or posedge h_reset) begin
    if (h_reset) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      dir_q      <= '0;
      otype_q    <= '0;
      out_q      <= '0;
      stat_q     <= '0;
      mask_q     <= '0;
      pos_q      <= '0;
      neg_q      <= '0;
      lvl_q      <= '0;
      filt_dly_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      ack_q      <= access;
      if (access) rdata_q <= rdata_d;
      dir_q      <= dir_d;
      otype_q    <= otype_d;
      out_q      <= out_d;
      stat_q     <= stat_d;
      mask_q     <= mask_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      lvl_q      <= lvl_d;
      filt_dly_q <= filt;
      sync_q[0]  <= gpio_in_data;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_ack    = ack_q;
  assign gpio_out_data  = out_q;
  assign gpio_out_en    = dir_q & (~otype_q | ~out_q);
  assign gpio_int_stat  = stat_q;
  assign gpio_intr      = |(stat_q & mask_q);

endmodule
